temp_seg7_display: RTL and testbench
====================================

Name: temp_seg7_display

Overview:
- Downstream consumer of the temperature top-level's 8-bit reading, i.e. the same byte that drives LED[7:0].
- Converts the unsigned byte to BCD with a sequential double-dabble engine.
- Drives the Basys 4-digit seven-segment display by time-multiplexing.
- Layout, left to right: hundreds, tens, ones, unit letter ('C' or 'F'). Leading zeros are blanked.

Parameters:
- REFRESH_DIV, 100000: clk_100MHz cycles each digit stays lit (1 kHz per digit, 250 Hz frame). Must be >= 2; benches override to 4.

Ports:
- clk_100MHz  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- temp_in  input  8  unsigned temperature, C or F, as selected upstream
- unit_f  input  1  1 = value is Fahrenheit (show 'F'), 0 = Celsius (show 'C'); same SW as upstream mux
- seg  output  7  cathodes, active-low, bit order {g,f,e,d,c,b,a}
- dp  output  1  decimal point, active-low; always 1 (off)
- an  output  4  anodes, active-low one-hot; an[0] is the rightmost digit

Behaviour:
- Reset (async assert, sync release):
  - seg=7'h7F, an=4'hF, dp=1.
  - Scan counter=0, digit index=0.
  - Displayed BCD {h,t,o} = 0; shown_valid=0; FSM=IDLE.
- Converter FSM, states IDLE, LOAD, SHIFT, DONE:
  - IDLE -> LOAD when shown_valid=0, or temp_in != last_val, or unit_f != last_unit.
  - LOAD: capture temp_in into shift register, unit_f into pending unit; clear 12-bit BCD accumulator; bit counter=0.
  - SHIFT: 8 cycles. Each cycle, first add 3 to every BCD nibble >=5, then shift {bcd,bin} left by 1. Leave after the 8th shift.
  - DONE: one cycle. Copy BCD to the displayed registers, last_val=captured value, last_unit=pending unit, shown_valid=1. Then return to IDLE.
  - Latency from input change to displayed-register update: 11 cycles (IDLE detect, LOAD, 8 SHIFT, DONE).
  - Input changes during LOAD/SHIFT are ignored. The mismatch is re-detected in IDLE and a new conversion starts; no partial value is ever displayed.
- Scan:
  - Free-running counter 0..REFRESH_DIV-1. On wrap, digit index increments 0->1->2->3->0.
  - an = ~(4'b0001 << index), registered, so an and seg change on the same edge.
- Digit content, using displayed registers only:
  - idx0: unit letter. 'C'=7'h46, 'F'=7'h0E.
  - idx1: ones digit, always shown.
  - idx2: tens; blank (7'h7F) if h==0 and t==0.
  - idx3: hundreds; blank if h==0.
  - Numeral codes 0..9: 40,79,24,30,19,12,02,78,00,10 (hex).
- Range: 0..255 only; no sign, no overflow case. An h nibble >2 cannot occur.
- Reset mid-conversion: everything returns to reset values. A fresh conversion starts immediately after release because shown_valid=0.

Decomposition:
- Package temp_disp_pkg holds:
  - Segment constants SEG_0..SEG_9, SEG_C, SEG_F, SEG_BLANK.
  - FSM state typedef (IDLE/LOAD/SHIFT/DONE).
  - Digit index width constant.
- One sub-module, bin2bcd_seq:
  - Ports: clock, reset, start, bin[7:0], busy, done, bcd[11:0].
  - Owns LOAD/SHIFT/DONE.
  - The top keeps change detection, displayed registers, scan counter and segment decode.

Test Plan:
- Reset held 5 cycles mid-SHIFT -> seg=7F, an=F, dp=1 during reset. After release, and within 11 cycles, displayed digits equal the current temp_in.
- temp_in=25, unit_f=0, REFRESH_DIV=4, sweep one full frame -> an sequence E,D,B,7 with seg 46,12,24,7F ('C','5','2',blank).
- temp_in=255, unit_f=1 -> idx0..3 show 0E,12,12,24 ('F','5','5','2').
- temp_in=0 -> idx1=40, idx2 and idx3 =7F. Then temp_in=100 -> 11 cycles later idx1..3 = 40,40,79.
- temp_in changes 77->78 on the 3rd SHIFT cycle -> 77 is displayed first. A second conversion follows, and 78 is displayed within 22 cycles of the change; no intermediate value appears.
- Only unit_f toggles, value stays 77 -> reconversion runs; idx0 switches 46<->0E after 11 cycles; numerals unchanged.

Source files
------------

// File: rtl/temp_seg7_display_pkg.sv
// ---------------------------------------------------------------------------
// temp_disp_pkg
// Shared definitions for the temperature seven-segment display:
//   - active-low segment patterns, bit order {g,f,e,d,c,b,a}
//   - converter FSM state type
//   - digit index width and a BCD-nibble-to-segment decode helper
// ---------------------------------------------------------------------------
package temp_disp_pkg;

   localparam int IDX_W = 2;  // four digits on the display

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_F     = 7'h0E;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } conv_state_t;

   function automatic logic [6:0] seg_digit(input logic [3:0] i_d);
      logic [6:0] r;
      case (i_d)
         4'd0:    r = SEG_0;
         4'd1:    r = SEG_1;
         4'd2:    r = SEG_2;
         4'd3:    r = SEG_3;
         4'd4:    r = SEG_4;
         4'd5:    r = SEG_5;
         4'd6:    r = SEG_6;
         4'd7:    r = SEG_7;
         4'd8:    r = SEG_8;
         4'd9:    r = SEG_9;
         default: r = SEG_BLANK;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/temp_seg7_display_if.sv
// ---------------------------------------------------------------------------
// temp_seg7_display_if
// Bundles the reading input and the display drive of temp_seg7_display.
//   temp_in [7:0] : unsigned temperature reading
//   unit_f        : 1 = Fahrenheit, 0 = Celsius
//   seg [6:0]     : active-low cathodes {g,f,e,d,c,b,a}
//   dp            : active-low decimal point
//   an [3:0]      : active-low one-hot anodes, an[0] = rightmost digit
// master = reading source / display observer, slave = the display block.
// ---------------------------------------------------------------------------
interface temp_seg7_display_if;
   logic [7:0] temp_in;
   logic       unit_f;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] an;

   modport master (output temp_in, unit_f, input seg, dp, an);
   modport slave  (input temp_in, unit_f, output seg, dp, an);
endinterface

// File: rtl/temp_seg7_display_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter, 8-bit binary to three BCD nibbles.
// One conversion: LOAD (1 cycle), SHIFT (8 cycles), DONE (1 cycle).
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_start      : request a conversion (accepted only in IDLE)
//   i_bin [7:0]  : value to convert, sampled during LOAD
//   o_busy       : high in LOAD, SHIFT and DONE
//   o_done       : high for the single DONE cycle; o_bcd is final then
//   o_bcd [11:0] : {hundreds, tens, ones}
// ---------------------------------------------------------------------------
module bin2bcd_seq
   import temp_disp_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic [7:0]  i_bin,
   output logic        o_busy,
   output logic        o_done,
   output logic [11:0] o_bcd
);

   conv_state_t r_state;
   conv_state_t w_next;
   logic [7:0]  r_bin;
   logic [11:0] r_bcd;
   logic [2:0]  r_bit_cnt;
   logic [11:0] w_bcd_adj;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // NOTE: every combinational output gets a default first so no path
   // leaves it unassigned (which would infer a latch).
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (i_start) w_next = LOAD;
         LOAD:    w_next = SHIFT;
         SHIFT:   if (r_bit_cnt == 3'd7) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      o_busy = (r_state != IDLE);
      o_done = (r_state == DONE);
   end

   // Add-3 correction applied before each shift so a nibble >= 5 carries
   // correctly into the next decade after doubling.
   always_comb begin
      w_bcd_adj = r_bcd;
      for (int i = 0; i < 3; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_bin     <= '0;
         r_bcd     <= '0;
         r_bit_cnt <= '0;
      end else begin
         case (r_state)
            LOAD: begin
               r_bin     <= i_bin;
               r_bcd     <= '0;
               r_bit_cnt <= '0;
            end
            SHIFT: begin
               {r_bcd, r_bin} <= {w_bcd_adj[10:0], r_bin, 1'b0};
               r_bit_cnt      <= r_bit_cnt + 3'd1;
            end
            default: ;
         endcase
      end
   end

   assign o_bcd = r_bcd;

endmodule

// File: rtl/temp_seg7_display.sv
// ---------------------------------------------------------------------------
// temp_seg7_display
// Shows an 8-bit temperature as up to three decimal digits plus a unit
// letter on a 4-digit multiplexed seven-segment display. Leading zeros are
// blanked. A new conversion starts whenever the input differs from what is
// currently shown; the shown value only changes once a conversion finishes.
//   clk_100MHz : system clock
//   reset      : asynchronous active-high reset
//   disp       : temp_in, unit_f in; seg, dp, an out (all active-low)
// Parameter REFRESH_DIV: clock cycles each digit stays lit (>= 2).
// ---------------------------------------------------------------------------
module temp_seg7_display
   import temp_disp_pkg::*;
#(
   parameter int REFRESH_DIV = 100000
) (
   input  logic           clk_100MHz,
   input  logic           reset,
   temp_seg7_display_if.slave disp
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   logic             w_start;
   logic             w_busy;
   logic             w_done;
   logic [11:0]      w_bcd;
   logic [6:0]       w_seg_next;

   logic             r_load;
   logic [7:0]       r_pend_val;
   logic             r_pend_unit;
   logic [7:0]       r_last_val;
   logic             r_last_unit;
   logic             r_shown_valid;
   logic [11:0]      r_disp_bcd;
   logic [CNT_W-1:0] r_scan_cnt;
   logic [IDX_W-1:0] r_idx;
   logic [6:0]       r_seg;
   logic [3:0]       r_an;

   assign w_start = !r_shown_valid
                 || (disp.temp_in != r_last_val)
                 || (disp.unit_f  != r_last_unit);

   bin2bcd_seq u_bin2bcd (
      .i_clk   (clk_100MHz),
      .i_rst   (reset),
      .i_start (w_start),
      .i_bin   (disp.temp_in),
      .o_busy  (w_busy),
      .o_done  (w_done),
      .o_bcd   (w_bcd)
   );

   // r_load marks the converter's LOAD cycle, so value and unit are captured
   // on the same edge the converter samples its input.
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         r_load        <= 1'b0;
         r_pend_val    <= '0;
         r_pend_unit   <= 1'b0;
         r_last_val    <= '0;
         r_last_unit   <= 1'b0;
         r_shown_valid <= 1'b0;
         r_disp_bcd    <= '0;
      end else begin
         r_load <= w_start && !w_busy;
         if (r_load) begin
            r_pend_val  <= disp.temp_in;
            r_pend_unit <= disp.unit_f;
         end
         if (w_done) begin
            r_disp_bcd    <= w_bcd;
            r_last_val    <= r_pend_val;
            r_last_unit   <= r_pend_unit;
            r_shown_valid <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         r_scan_cnt <= '0;
         r_idx      <= '0;
      end else if (r_scan_cnt == CNT_W'(REFRESH_DIV - 1)) begin
         r_scan_cnt <= '0;
         r_idx      <= r_idx + IDX_W'(1);
      end else begin
         r_scan_cnt <= r_scan_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      w_seg_next = SEG_BLANK;
      case (r_idx)
         2'd0: w_seg_next = r_last_unit ? SEG_F : SEG_C;
         2'd1: w_seg_next = seg_digit(r_disp_bcd[3:0]);
         2'd2: if (r_disp_bcd[11:4] != 8'd0) w_seg_next = seg_digit(r_disp_bcd[7:4]);
         2'd3: if (r_disp_bcd[11:8] != 4'd0) w_seg_next = seg_digit(r_disp_bcd[11:8]);
         default: w_seg_next = SEG_BLANK;
      endcase
   end

   // seg and an are both registered from the same index so they switch
   // together and never show one digit's pattern on a neighbouring anode.
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         r_seg <= SEG_BLANK;
         r_an  <= 4'hF;
      end else begin
         r_seg <= w_seg_next;
         r_an  <= ~(4'b0001 << r_idx);
      end
   end

   assign disp.seg = r_seg;
   assign disp.an  = r_an;
   assign disp.dp  = 1'b1;

endmodule

// File: tb/tb_temp_seg7_display.sv
// ---------------------------------------------------------------------------
// tb_temp_seg7_display
// Directed bench for temp_seg7_display with REFRESH_DIV = 4 (16-cycle frame).
// ---------------------------------------------------------------------------
module tb_temp_seg7_display;

   localparam int RDIV = 4;

   logic clk_100MHz = 1'b0;
   logic reset;

   always #5 clk_100MHz = ~clk_100MHz;

   temp_seg7_display_if disp_if ();

   temp_seg7_display #(.REFRESH_DIV(RDIV)) dut (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .disp       (disp_if)
   );

   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk_100MHz);
   endtask

   // Returns on the first negedge at which an shows a_exp (after having
   // shown something else), i.e. the first sample of that digit's window.
   task automatic wait_an(input logic [3:0] a_exp);
      int k;
      k = 0;
      while (disp_if.an == a_exp && k < 64) begin
         @(negedge clk_100MHz);
         k++;
      end
      while (disp_if.an != a_exp && k < 64) begin
         @(negedge clk_100MHz);
         k++;
      end
      if (k >= 64) check($sformatf("scan_timeout_an%0h", a_exp), 32'(k), 32'd0);
   endtask

   task automatic check_frame(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3);
      logic [3:0][6:0] exp_seg;
      logic [3:0]      a;
      exp_seg = {e3, e2, e1, e0};
      for (int k = 0; k < 4; k++) begin
         a = ~(4'b0001 << k);
         wait_an(a);
         check($sformatf("%s_idx%0d", tag, k), 32'(disp_if.seg), 32'(exp_seg[k]));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [3:0][3:0] an_seq;
      logic [3:0][6:0] seg_seq;
      int              n_glitch;

      // ---- reset state ----
      reset           = 1'b1;
      disp_if.temp_in = 8'd123;
      disp_if.unit_f  = 1'b0;
      tick(3);
      check("rst_seg", 32'(disp_if.seg), 32'h7F);
      check("rst_an",  32'(disp_if.an),  32'hF);
      check("rst_dp",  32'(disp_if.dp),  32'h1);
      reset = 1'b0;
      tick(20);
      check_frame("v123", 7'h46, 7'h30, 7'h24, 7'h79);

      // ---- reset held 5 cycles in the middle of SHIFT ----
      disp_if.temp_in = 8'd45;
      tick(5);
      reset = 1'b1;
      tick(1);
      check("midrst_seg", 32'(disp_if.seg), 32'h7F);
      check("midrst_an",  32'(disp_if.an),  32'hF);
      tick(4);
      check("midrst_seg_end", 32'(disp_if.seg), 32'h7F);
      check("midrst_an_end",  32'(disp_if.an),  32'hF);
      check("midrst_dp",      32'(disp_if.dp),  32'h1);
      reset = 1'b0;
      tick(12);
      check_frame("v45_after_rst", 7'h46, 7'h12, 7'h19, 7'h7F);

      // ---- 25 C: one full frame, anode order and patterns ----
      disp_if.temp_in = 8'd25;
      tick(14);
      an_seq  = {4'h7, 4'hB, 4'hD, 4'hE};
      seg_seq = {7'h7F, 7'h24, 7'h12, 7'h46};
      wait_an(4'hE);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("v25_an%0d", k),  32'(disp_if.an),  32'(an_seq[k]));
         check($sformatf("v25_seg%0d", k), 32'(disp_if.seg), 32'(seg_seq[k]));
         tick(RDIV);
      end

      // ---- 255 F: largest value ----
      disp_if.temp_in = 8'd255;
      disp_if.unit_f  = 1'b1;
      tick(14);
      check_frame("v255F", 7'h0E, 7'h12, 7'h12, 7'h24);

      // ---- 0: only the ones digit lit ----
      disp_if.temp_in = 8'd0;
      disp_if.unit_f  = 1'b0;
      tick(14);
      check_frame("v0", 7'h46, 7'h40, 7'h7F, 7'h7F);

      // ---- 100: inner zeros shown ----
      disp_if.temp_in = 8'd100;
      tick(13);
      check_frame("v100", 7'h46, 7'h40, 7'h40, 7'h79);

      // ---- 77 -> 78 change on the 3rd SHIFT cycle ----
      // Align so the ones digit is lit just after 77 lands (rel 13..16)
      // and again after 78 lands (rel 29..32).
      wait_an(4'hD);
      tick(3);
      disp_if.temp_in = 8'd77;   // rel 0
      tick(4);
      disp_if.temp_in = 8'd78;   // rel 4: converter in its 3rd SHIFT cycle
      n_glitch = 0;
      for (int rel = 5; rel <= 40; rel++) begin
         tick(1);
         case (disp_if.an)
            4'hE: if (disp_if.seg != 7'h46) n_glitch++;
            4'hD: if (!(disp_if.seg inside {7'h40, 7'h78, 7'h00})) n_glitch++;
            4'hB: if (!(disp_if.seg inside {7'h40, 7'h78})) n_glitch++;
            4'h7: if (!(disp_if.seg inside {7'h79, 7'h7F})) n_glitch++;
            default: n_glitch++;
         endcase
         if (rel == 13) begin
            check("v77_first_an",   32'(disp_if.an),  32'hD);
            check("v77_first_ones", 32'(disp_if.seg), 32'h78);
         end
         if (rel == 17) begin
            check("v77_first_tens_an", 32'(disp_if.an),  32'hB);
            check("v77_first_tens",    32'(disp_if.seg), 32'h78);
         end
         if (rel == 29) begin
            check("v78_ones_an", 32'(disp_if.an),  32'hD);
            check("v78_ones",    32'(disp_if.seg), 32'h00);
         end
      end
      check("v77_78_no_intermediate", 32'(n_glitch), 32'd0);

      // ---- unit toggle only, value stays 77: exact 11-cycle latency ----
      disp_if.temp_in = 8'd77;
      tick(30);
      wait_an(4'hE);
      tick(7);
      disp_if.unit_f = 1'b1;     // rel 0; unit digit lit again at rel 9..12
      tick(11);
      check("unit_rel11_an",  32'(disp_if.an),  32'hE);
      check("unit_rel11_old", 32'(disp_if.seg), 32'h46);
      tick(1);
      check("unit_rel12_an",  32'(disp_if.an),  32'hE);
      check("unit_rel12_new", 32'(disp_if.seg), 32'h0E);
      check_frame("v77F", 7'h0E, 7'h78, 7'h78, 7'h7F);

      disp_if.unit_f = 1'b0;
      tick(14);
      check_frame("v77C", 7'h46, 7'h78, 7'h78, 7'h7F);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
